mac_acc_ctrl: RTL

- Sequencer that reduces a stream of i_len DATA_W-bit products to one sum, using the shared pipelined 3-stage mac_adder in a feedback loop.
- Pairs returning partial sums with new products so that a fully pipelined adder is kept busy without hazards.
- Sits between the multiplier output stream and the accumulator result register; the parent instantiates mac_adder and wires o_add_*/i_add_* to it.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_acc_ctrl_chk.sv | 28 ++
 rtl/mac_acc_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulation controller.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

  localparam int MAC_ADDER_LAT = 3;
  localparam int MAC_DATA_W    = 32;
  localparam int MAC_LEN_W     = 16;

endpackage

// File: rtl/mac_acc_ctrl_chk.sv
// Property checker for mac_acc_ctrl: park occupancy, adder occupancy and
// adder results arriving while the controller is idle.
module mac_acc_ctrl_chk
  import mac_pkg::*;
#(
  parameter int ADDER_LAT = MAC_ADDER_LAT,
  parameter int INFL_W    = 3
) (
  input logic              i_clk,
  input logic              i_rst,
  input mac_state_e        state,
  input logic              i_add_valid,
  input logic              park_push,
  input logic              park_pop,
  input logic              park_full,
  input logic [INFL_W-1:0] inflight
);

  park_no_overflow_a : assert property (@(posedge i_clk) disable iff (i_rst)
    (park_push && park_full) |-> park_pop);

  inflight_bound_a : assert property (@(posedge i_clk) disable iff (i_rst)
    inflight <= INFL_W'(ADDER_LAT));

  no_result_in_idle_a : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_add_valid && (state == ST_IDLE)));

endmodule

// File: rtl/mac_acc_ctrl.sv
// Reduces a stream of products to one sum by feeding partial sums back
// through an external pipelined adder, pairing operands so it never stalls.
module mac_acc_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_W    = MAC_DATA_W,
  parameter int LEN_W     = MAC_LEN_W,
  parameter int ADDER_LAT = MAC_ADDER_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_prod,
  input  logic              i_prod_valid,
  output logic              o_prod_ready,
  output logic [DATA_W-1:0] o_add_a,
  output logic [DATA_W-1:0] o_add_b,
  output logic              o_add_valid,
  input  logic [DATA_W-1:0] i_add_val,
  input  logic              i_add_valid,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_acc_valid,
  output logic              o_busy
);

  localparam int INFL_W = $clog2(ADDER_LAT + 2);

  mac_state_e        state_r;
  mac_state_e        state_next_s;
  logic [LEN_W-1:0]  remaining_r;
  logic [DATA_W-1:0] park_r;
  logic              park_full_r;
  logic [INFL_W-1:0] inflight_r;
  logic [DATA_W-1:0] add_a_r;
  logic [DATA_W-1:0] add_b_r;
  logic              add_valid_r;
  logic [DATA_W-1:0] acc_r;
  logic              acc_valid_r;

  logic              r_v_s;
  logic              p_v_s;
  logic              k_v_s;
  logic [1:0]        cand_cnt_s;
  logic              issue_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic              park_push_s;
  logic              park_pop_s;
  logic [DATA_W-1:0] park_in_s;
  logic              drain_done_s;

  // Operand pairing: results first, then products, then the parked value.
  always_comb begin
    r_v_s       = i_add_valid && ((state_r == ST_ACCUM) || (state_r == ST_DRAIN));
    p_v_s       = i_prod_valid && (state_r == ST_ACCUM);
    k_v_s       = park_full_r;
    cand_cnt_s  = {1'b0, r_v_s} + {1'b0, p_v_s} + {1'b0, k_v_s};
    issue_s     = (cand_cnt_s >= 2'd2);
    op_a_s      = {DATA_W{1'b0}};
    op_b_s      = {DATA_W{1'b0}};
    if (r_v_s) begin
      op_a_s = i_add_val;
      op_b_s = p_v_s ? i_prod : park_r;
    end else if (p_v_s) begin
      op_a_s = i_prod;
      op_b_s = park_r;
    end else begin
      op_a_s = {DATA_W{1'b0}};
      op_b_s = {DATA_W{1'b0}};
    end
    park_push_s  = (cand_cnt_s == 2'd1) && !k_v_s;
    park_pop_s   = issue_s && k_v_s && (cand_cnt_s == 2'd2);
    park_in_s    = r_v_s ? i_add_val : i_prod;
    drain_done_s = (inflight_r == INFL_W'(0)) && !add_valid_r && !issue_s &&
                   !i_add_valid && park_full_r;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_next_s = (i_len == LEN_W'(0)) ? ST_DONE : ST_ACCUM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (p_v_s && (remaining_r == LEN_W'(1))) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Products still to be accepted in this reduction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      remaining_r <= LEN_W'(0);
    end else if ((state_r == ST_IDLE) && i_start) begin
      remaining_r <= i_len;
    end else if (p_v_s && (remaining_r != LEN_W'(0))) begin
      remaining_r <= remaining_r - LEN_W'(1);
    end
  end

  // Single-entry park register holding the operand left without a partner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      park_r      <= {DATA_W{1'b0}};
      park_full_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      if (i_start && (i_len == LEN_W'(0))) begin
        park_r      <= {DATA_W{1'b0}};
        park_full_r <= 1'b1;
      end
    end else if (state_r == ST_DONE) begin
      park_r      <= {DATA_W{1'b0}};
      park_full_r <= 1'b0;
    end else if (park_push_s) begin
      park_r      <= park_in_s;
      park_full_r <= 1'b1;
    end else if (park_pop_s) begin
      park_full_r <= 1'b0;
    end
  end

  // Operations currently inside the adder pipeline.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_r <= INFL_W'(0);
    end else begin
      case ({add_valid_r, r_v_s})
        2'b10:   inflight_r <= inflight_r + INFL_W'(1);
        2'b01:   inflight_r <= inflight_r - INFL_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Registered adder issue; operands hold when nothing is issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      add_a_r     <= {DATA_W{1'b0}};
      add_b_r     <= {DATA_W{1'b0}};
      add_valid_r <= 1'b0;
    end else begin
      add_valid_r <= issue_s;
      if (issue_s) begin
        add_a_r <= op_a_s;
        add_b_r <= op_b_s;
      end
    end
  end

  // Final sum register and its one-cycle strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_r       <= {DATA_W{1'b0}};
      acc_valid_r <= 1'b0;
    end else begin
      acc_valid_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        acc_r <= park_r;
      end
    end
  end

  assign o_prod_ready = (state_r == ST_ACCUM);
  assign o_busy       = (state_r != ST_IDLE);
  assign o_add_a      = add_a_r;
  assign o_add_b      = add_b_r;
  assign o_add_valid  = add_valid_r;
  assign o_acc        = acc_r;
  assign o_acc_valid  = acc_valid_r;

endmodule
